shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the barrel-less shift datapath (LSL/LSR/ASR/ROR).
//  Accepts one shift request via start pulse. Moves the operand one bit per clock.
//  Returns Rd plus N/Z/C flags with a done pulse.
//  Sits between decode/execute and the register file; frees the core from combinational shifting.
// PARAMETERS
//  WIDTH   32  operand/result width (flag rules below assume 32)
//  AMT_W   8   shift-amount width (Rs[7:0] or imm5 zero-extended)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request pulse; sampled only in IDLE
//  S          in   1      1 = update flags from result, 0 = pass flags through
//  stype      in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//  Rm         in   WIDTH  operand to shift
//  amount     in   AMT_W  shift amount
//  carry_in   in   1      current C flag
//  zero_in    in   1      current Z flag
//  neg_in     in   1      current N flag
//  busy       out  1      high from the cycle after start acceptance until done
//  done       out  1      one-cycle pulse: Rd/flags valid
//  Rd         out  WIDTH  result, held until next accepted start
//  carry_out  out  1      C result, held
//  zero_out   out  1      Z result, held
//  neg_out    out  1      N result, held
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, Rd=0, carry_out=0, zero_out=0, neg_out=0; counter=0.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: start=1 captures Rm, stype, S, amount, and all three flag inputs.
//   - IDLE -> SHIFT if effective count k>0; IDLE -> DONE if k==0.
//   - SHIFT: one bit per cycle; decrement counter; go to DONE when counter reaches 1.
//   - DONE: done=1 for exactly one cycle; busy=0 in DONE; return to IDLE.
//   - start is ignored in SHIFT/DONE; no queuing.
//  Latency: start sampled at edge T -> done high in cycle T+1+k.
//  Effective count k:
//   - LSL/LSR/ASR: k = min(amount, 33).
//   - ROR: k = amount[4:0].
//  Per step:
//   - LSL: c=r[31], r={r[30:0],0}.
//   - LSR: c=r[0], r={0,r[31:1]}.
//   - ASR: c=r[0], r={r[31],r[31:1]}.
//   - ROR: c=r[0], r={r[0],r[31:1]}.
//  Carry rules (ARMv6-M):
//   - amount==0: C unchanged (carry_in), result=Rm.
//   - LSL/LSR >=33: result 0, C=0 (falls out of clamp).
//   - LSR 32: result 0, C=Rm[31].
//   - ASR >=32: result={32{Rm[31]}}, C=Rm[31].
//   - ROR with amount!=0 and amount[4:0]==0: k=0, result=Rm, C=Rm[31].
//  Flags:
//   - S=1: N=Rd[31], Z=(Rd==0), C per rules above.
//   - S=0: all three flags = captured inputs.
//   - Flag outputs update on entry to DONE, simultaneously with Rd.
//  Rd/flags change only on entry to DONE; otherwise hold the previous result.
//  Reset mid-SHIFT aborts the operation: no done pulse; outputs go to reset values.
//  Inputs other than start are don't-care after capture; they may change during SHIFT.
// TESTING
//  1. LSL, Rm=0x80000001, amount=1, S=1 -> done at T+2; Rd=0x00000002, C=1, N=0, Z=0.
//  2. LSR, Rm=0x80000000, amount=32, S=1 -> done at T+33; Rd=0, C=1, Z=1, N=0.
//  3. ASR, Rm=0x80000000, amount=40, S=1 -> done at T+34 (k=33); Rd=0xFFFFFFFF, C=1, N=1.
//  4. ROR, Rm=0x00000011, amount=36, S=1 -> k=4, done at T+5; Rd=0x10000001, C=0, N=0.
//  5. Shift by zero:
//     - LSL, amount=0, carry_in=1, S=1, Rm=0 -> done at T+1; Rd=0, C=1, Z=1.
//     - ROR, amount=32, Rm=0x80000000 -> Rd=Rm, C=1.
//  6. Control hazards:
//     - start pulsed during SHIFT -> ignored; first result intact.
//     - S=0 -> flags equal inputs.
//     - rst_n low mid-SHIFT -> busy=0, no done, Rd=0.

Source files
------------

// File: rtl/shift_sequencer.sv
// ============================================================================
//  shift_sequencer : bit-serial LSL/LSR/ASR/ROR sequencer with N/Z/C flags
//  Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             S_i,
    input  logic [1:0]       stype_i,
    input  logic [WIDTH-1:0] Rm_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             carry_in_i,
    input  logic             zero_in_i,
    input  logic             neg_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] Rd_o,
    output logic             carry_out_o,
    output logic             zero_out_o,
    output logic             neg_out_o
);

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam int         CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   r_q;
    logic [1:0]         stype_q;
    logic               s_q;
    logic               cin_q, zin_q, nin_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   Rd_q;
    logic               carry_q, zero_q, neg_q;

    logic [CNT_W-1:0]   k_d;
    logic [WIDTH-1:0]   r_step_d;
    logic               c_step_d;
    logic               c_zero_d;

    // Shifts past 33 cannot change the result further, so the count saturates there.
    always_comb begin
        k_d = '0;
        if (stype_i == ROR) begin
            k_d = {1'b0, amount_i[4:0]};
        end else if (amount_i > AMT_W'(33)) begin
            k_d = CNT_W'(33);
        end else begin
            k_d = amount_i[CNT_W-1:0];
        end
        // A non-zero rotate that is a multiple of the width still reports bit 31 as carry.
        c_zero_d = (amount_i == '0) ? carry_in_i : Rm_i[WIDTH-1];
    end

    always_comb begin
        r_step_d = r_q;
        c_step_d = 1'b0;
        case (stype_q)
            LSL: begin
                c_step_d = r_q[WIDTH-1];
                r_step_d = {r_q[WIDTH-2:0], 1'b0};
            end
            LSR: begin
                c_step_d = r_q[0];
                r_step_d = {1'b0, r_q[WIDTH-1:1]};
            end
            ASR: begin
                c_step_d = r_q[0];
                r_step_d = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            end
            default: begin
                c_step_d = r_q[0];
                r_step_d = {r_q[0], r_q[WIDTH-1:1]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            stype_q <= LSL;
            s_q     <= 1'b0;
            cin_q   <= 1'b0;
            zin_q   <= 1'b0;
            nin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            Rd_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        r_q     <= Rm_i;
                        stype_q <= stype_i;
                        s_q     <= S_i;
                        cin_q   <= carry_in_i;
                        zin_q   <= zero_in_i;
                        nin_q   <= neg_in_i;
                        if (k_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            Rd_q    <= Rm_i;
                            carry_q <= S_i ? c_zero_d          : carry_in_i;
                            zero_q  <= S_i ? (Rm_i == '0)      : zero_in_i;
                            neg_q   <= S_i ? Rm_i[WIDTH-1]     : neg_in_i;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                            cnt_q   <= k_d;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_q   <= r_step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        Rd_q    <= r_step_d;
                        carry_q <= s_q ? c_step_d              : cin_q;
                        zero_q  <= s_q ? (r_step_d == '0)      : zin_q;
                        neg_q   <= s_q ? r_step_d[WIDTH-1]     : nin_q;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign Rd_o        = Rd_q;
    assign carry_out_o = carry_q;
    assign zero_out_o  = zero_q;
    assign neg_out_o   = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
//  tb_shift_sequencer : directed bench for shift_sequencer with a reference model
//  Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        S_i = 1'b0;
    logic [1:0]  stype_i = 2'b00;
    logic [31:0] Rm_i = '0;
    logic [7:0]  amount_i = '0;
    logic        carry_in_i = 1'b0;
    logic        zero_in_i = 1'b0;
    logic        neg_in_i = 1'b0;
    logic        busy_o, done_o, carry_out_o, zero_out_o, neg_out_o;
    logic [31:0] Rd_o;

    shift_sequencer #(.WIDTH(32), .AMT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .S_i         (S_i),
        .stype_i     (stype_i),
        .Rm_i        (Rm_i),
        .amount_i    (amount_i),
        .carry_in_i  (carry_in_i),
        .zero_in_i   (zero_in_i),
        .neg_in_i    (neg_in_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .Rd_o        (Rd_o),
        .carry_out_o (carry_out_o),
        .zero_out_o  (zero_out_o),
        .neg_out_o   (neg_out_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARMv6-M shifter semantics in closed form.
    function automatic void ref_shift(input logic [1:0] st, input logic [31:0] rm,
                                      input int amt, input logic cin,
                                      output logic [31:0] rd, output logic c, output int k);
        int r;
        rd = rm;
        c  = cin;
        k  = (st == 2'b11) ? (amt % 32) : ((amt > 33) ? 33 : amt);
        if (amt == 0) return;
        case (st)
            2'b00: begin
                if (amt < 32)       begin rd = rm << amt; c = rm[32-amt]; end
                else if (amt == 32) begin rd = '0;        c = rm[0];      end
                else                begin rd = '0;        c = 1'b0;       end
            end
            2'b01: begin
                if (amt < 32)       begin rd = rm >> amt; c = rm[amt-1];  end
                else if (amt == 32) begin rd = '0;        c = rm[31];     end
                else                begin rd = '0;        c = 1'b0;       end
            end
            2'b10: begin
                if (amt < 32) begin rd = 32'($signed(rm) >>> amt); c = rm[amt-1]; end
                else          begin rd = {32{rm[31]}};             c = rm[31];    end
            end
            default: begin
                r = amt % 32;
                if (r == 0) begin rd = rm; c = rm[31]; end
                else begin rd = (rm >> r) | (rm << (32 - r)); c = rm[r-1]; end
            end
        endcase
    endfunction

    // Transaction-level model: accept, wait k edges, present result for one cycle.
    logic        m_busy, m_done, m_c, m_n, m_z;
    logic [31:0] m_rd;
    logic        p_c, p_n, p_z;
    logic [31:0] p_rd;
    int          m_rem;
    logic [31:0] t_rd;
    logic        t_c;
    int          t_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
            m_rd = '0; m_c = 1'b0; m_n = 1'b0; m_z = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_rd = p_rd; m_c = p_c; m_n = p_n; m_z = p_z;
            end
        end else if (start_i) begin
            ref_shift(stype_i, Rm_i, int'(amount_i), carry_in_i, t_rd, t_c, t_k);
            p_rd = t_rd;
            p_c  = S_i ? t_c            : carry_in_i;
            p_n  = S_i ? t_rd[31]       : neg_in_i;
            p_z  = S_i ? (t_rd == '0)   : zero_in_i;
            if (t_k == 0) begin
                m_done = 1'b1;
                m_rd = p_rd; m_c = p_c; m_n = p_n; m_z = p_z;
            end else begin
                m_busy = 1'b1;
                m_rem  = t_k;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("cyc_busy", 32'(busy_o), 32'(m_busy));
            check("cyc_done", 32'(done_o), 32'(m_done));
            check("cyc_rd",   Rd_o,        m_rd);
            check("cyc_c",    32'(carry_out_o), 32'(m_c));
            check("cyc_n",    32'(neg_out_o),   32'(m_n));
            check("cyc_z",    32'(zero_out_o),  32'(m_z));
        end
    end

    task automatic run_op(input string name, input logic [1:0] st, input logic [31:0] rm,
                          input logic [7:0] amt, input logic s,
                          input logic cin, input logic zin, input logic nin,
                          input logic [31:0] e_rd, input logic e_c, input logic e_n,
                          input logic e_z, input int e_k, input bit poke);
        int n;
        @(negedge clk);
        stype_i = st; Rm_i = rm; amount_i = amt; S_i = s;
        carry_in_i = cin; zero_in_i = zin; neg_in_i = nin;
        start_i = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        Rm_i       = $urandom;
        amount_i   = 8'($urandom);
        stype_i    = 2'($urandom);
        S_i        = ~s;
        carry_in_i = 1'($urandom);
        zero_in_i  = 1'($urandom);
        neg_in_i   = 1'($urandom);
        n = 0;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
            start_i = (poke && n == 1);
        end
        start_i = 1'b0;
        // done observed k edges after the accepting edge, i.e. in cycle T+1+k
        check({name, "_lat"}, 32'(n), 32'(e_k));
        check({name, "_rd"},  Rd_o, e_rd);
        check({name, "_c"},   32'(carry_out_o), 32'(e_c));
        check({name, "_n"},   32'(neg_out_o),   32'(e_n));
        check({name, "_z"},   32'(zero_out_o),  32'(e_z));
        @(negedge clk);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rd",   Rd_o, 32'd0);
        check("rst_flags", {29'd0, carry_out_o, zero_out_o, neg_out_o}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        //     name    type   Rm            amt  S  cin zin nin  Rd            C  N  Z  k   poke
        run_op("lsl1", 2'b00, 32'h80000001, 1,   1, 0,  0,  0,   32'h00000002, 1, 0, 0, 1,  0);
        run_op("lsr32",2'b01, 32'h80000000, 32,  1, 0,  0,  0,   32'h00000000, 1, 0, 1, 32, 0);
        run_op("asr40",2'b10, 32'h80000000, 40,  1, 0,  0,  0,   32'hFFFFFFFF, 1, 1, 0, 33, 0);
        run_op("ror36",2'b11, 32'h00000011, 36,  1, 0,  0,  0,   32'h10000001, 0, 0, 0, 4,  0);
        run_op("lsl0", 2'b00, 32'h00000000, 0,   1, 1,  0,  0,   32'h00000000, 1, 0, 1, 0,  0);
        run_op("ror32",2'b11, 32'h80000000, 32,  1, 0,  0,  0,   32'h80000000, 1, 1, 0, 0,  0);
        run_op("s0",   2'b00, 32'h00000001, 4,   0, 0,  1,  1,   32'h00000010, 0, 1, 1, 4,  0);
        run_op("lsl33",2'b00, 32'hFFFFFFFF, 33,  1, 1,  0,  0,   32'h00000000, 0, 0, 1, 33, 0);
        run_op("lsl32",2'b00, 32'h00000001, 32,  1, 0,  0,  0,   32'h00000000, 1, 0, 1, 32, 0);
        run_op("lsr33",2'b01, 32'hFFFFFFFF, 33,  1, 1,  0,  0,   32'h00000000, 0, 0, 1, 33, 0);
        run_op("lsr200",2'b01,32'h80000000, 200, 1, 1,  0,  0,   32'h00000000, 0, 0, 1, 33, 0);
        run_op("asr3", 2'b10, 32'h7FFFFFF0, 3,   1, 1,  0,  0,   32'h0FFFFFFE, 0, 0, 0, 3,  0);
        run_op("ror1", 2'b11, 32'h00000001, 1,   1, 0,  0,  0,   32'h80000000, 1, 1, 0, 1,  0);
        run_op("poke", 2'b01, 32'h000000F0, 4,   1, 1,  0,  0,   32'h0000000F, 0, 0, 0, 4,  1);

        // Abort a long shift with reset: no done pulse may follow.
        @(negedge clk);
        stype_i = 2'b00; Rm_i = 32'h12345678; amount_i = 8'd20; S_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_rd",   Rd_o, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check("abort_nodone", 32'(seen), 32'd0);

        run_op("after",2'b00, 32'h00000003, 2,   1, 0,  0,  0,   32'h0000000C, 0, 0, 0, 2,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
